// File: rtl/fifo_rd_stream.sv
// Pops words from an upstream synchronous FIFO into a 2-entry skid buffer and presents them as a
// valid/ready stream with packet framing. Optional sticky error flag under FIFO_RD_STREAM_ERR_CHK_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fifo_empty_in,
    output logic                  fifo_pop_req_out,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_error_in,
    output logic                  m_valid_out,
    input  logic                  m_ready_in,
    output logic [DATA_WIDTH-1:0] m_data_out,
    output logic                  m_last_out,
    output logic                  err_out
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    logic [1:0]            occ;
    logic                  infl;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic [BEAT_W-1:0]     beat_cnt;

    logic                  handshake;
    logic [2:0]            level;
    logic                  pop;
    logic                  cap;
    logic [1:0]            occ_after_hs;
    logic                  overflow;
    logic                  cap_ok;
    logic [1:0]            occ_next;
    logic [DATA_WIDTH-1:0] entry0_next;
    logic [DATA_WIDTH-1:0] entry1_next;

    // Stream handshake: a word transfers when m_valid_out and m_ready_in are both high in a cycle;
    // the head entry leaves at that clock edge, and valid/data hold steady while ready is low.
    assign handshake = valid_q && m_ready_in;

    // Words buffered plus words still in the FIFO read pipe, net of the one leaving this cycle.
    assign level            = {1'b0, occ} + {2'b0, infl} - {2'b0, handshake};
    assign pop              = rstn && !fifo_empty_in && (level < 3'd2);
    assign fifo_pop_req_out = pop;

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign infl = 1'b0;
            assign cap  = pop;
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    infl <= 1'b0;
                end else begin
                    infl <= pop;
                end
            end
            assign cap = infl;
        end
    endgenerate

    assign occ_after_hs = occ - {1'b0, handshake};
    assign overflow     = cap && (occ_after_hs == 2'd2);
    assign cap_ok       = cap && !overflow;
    assign occ_next     = occ_after_hs + {1'b0, cap_ok};

    // Head shifts out on a handshake; a captured word lands in the first free slot after that.
    always_comb begin
        entry0_next = entry0;
        entry1_next = entry1;
        if (handshake) begin
            entry0_next = entry1;
        end
        if (cap_ok) begin
            if (occ_after_hs == 2'd0) begin
                entry0_next = fifo_data_in;
            end else begin
                entry1_next = fifo_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ     <= 2'd0;
            valid_q <= 1'b0;
            entry0  <= '0;
            entry1  <= '0;
        end else begin
            occ     <= occ_next;
            valid_q <= (occ_next != 2'd0);
            entry0  <= entry0_next;
            entry1  <= entry1_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (handshake) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BEAT_ONE;
            end
        end
    end

    assign m_valid_out = valid_q;
    assign m_data_out  = entry0;
    assign m_last_out  = valid_q && (beat_cnt == BEAT_LAST);

`ifdef FIFO_RD_STREAM_ERR_CHK_EN
    logic err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (fifo_error_in || overflow) begin
            err <= 1'b1;
        end
    end

    assign err_out = err;
`else
    // Folds to a constant 0; the reference only keeps the error input connected.
    assign err_out = fifo_error_in & 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one instance per read latency, shared stream ready, upstream FIFO models,
// a table of streaming scenarios and hand-written corner sequences.
module tb_fifo_rd_stream;
  localparam int W   = 16;
  localparam int PKT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, ready, err_in;
  logic empty0, empty1, pop0, pop1, valid0, valid1, last0, last1, err0, err1;
  logic [W-1:0] din0, din1, dout0, dout1;

  fifo_rd_stream #(.DATA_WIDTH(W), .RD_LATENCY(0), .PKT_LEN(PKT)) dut_lat0 (
    .clk(clk), .rstn(rstn), .fifo_empty_in(empty0), .fifo_pop_req_out(pop0),
    .fifo_data_in(din0), .fifo_error_in(err_in), .m_valid_out(valid0),
    .m_ready_in(ready), .m_data_out(dout0), .m_last_out(last0), .err_out(err0)
  );

  fifo_rd_stream #(.DATA_WIDTH(W), .RD_LATENCY(1), .PKT_LEN(PKT)) dut_lat1 (
    .clk(clk), .rstn(rstn), .fifo_empty_in(empty1), .fifo_pop_req_out(pop1),
    .fifo_data_in(din1), .fifo_error_in(err_in), .m_valid_out(valid1),
    .m_ready_in(ready), .m_data_out(dout1), .m_last_out(last1), .err_out(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] fq0[$], fq1[$];
  logic [W-1:0] exp_q0[$], exp_q1[$];

  int beat_m[2];
  int beats_n[2], lasts_n[2], pops_n[2];
  int hs_first[2], hs_last[2], pop_cyc[2], valid_cyc[2];
  bit stall_p[2];
  logic [W-1:0] data_p[2];
  bit pop_s[2];
  bit err_s;
  logic err_exp;

  typedef struct {
    int n_words;
    int mode;
    int exp_beats;
    int exp_lasts;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    empty0 = (fq0.size() == 0);
    din0   = (fq0.size() != 0) ? fq0[0] : W'($urandom);
    empty1 = (fq1.size() == 0);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fq0.push_back(w);
    fq1.push_back(w);
    exp_q0.push_back(w);
    exp_q1.push_back(w);
    refresh();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      beats_n[i] = 0; lasts_n[i] = 0; pops_n[i] = 0;
      hs_first[i] = -1; hs_last[i] = -1; pop_cyc[i] = -1; valid_cyc[i] = -1;
    end
  endtask

  task automatic mon(input int i, input logic v, input logic [W-1:0] d, input logic l,
                     input logic p, input logic e, input logic er);
    logic [W-1:0] exp_d;
    bit have;
    check($sformatf("pop_when_empty[%0d]", i), {31'd0, p & e}, 32'd0);
    if (!rstn) check($sformatf("pop_in_reset[%0d]", i), {31'd0, p}, 32'd0);
    if (rstn) check($sformatf("err[%0d]", i), {31'd0, er}, {31'd0, err_exp});
    if (stall_p[i]) begin
      check($sformatf("valid_hold[%0d]", i), {31'd0, v}, 32'd1);
      check($sformatf("data_hold[%0d]", i), {16'd0, d}, {16'd0, data_p[i]});
    end
    if (!v) check($sformatf("last_idle[%0d]", i), {31'd0, l}, 32'd0);
    if (rstn && v && ready) begin
      beats_n[i]++;
      if (l) lasts_n[i]++;
      if (hs_first[i] < 0) hs_first[i] = cyc;
      hs_last[i] = cyc;
      have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat[%0d]: got %0h expected no word (cycle %0d)", i, d, cyc);
      end else begin
        exp_d = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("beat_data[%0d]", i), {16'd0, d}, {16'd0, exp_d});
        check($sformatf("beat_last[%0d]", i), {31'd0, l}, {31'd0, beat_m[i] == PKT - 1});
        beat_m[i] = (beat_m[i] + 1) % PKT;
      end
    end
    if (rstn && p) begin
      pops_n[i]++;
      if (pop_cyc[i] < 0) pop_cyc[i] = cyc;
    end
    if (rstn && v && valid_cyc[i] < 0) valid_cyc[i] = cyc;
    stall_p[i] = v && !ready;
    data_p[i]  = d;
    pop_s[i]   = p;
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, valid0, dout0, last0, pop0, empty0, err0);
    mon(1, valid1, dout1, last1, pop1, empty1, err1);
    err_s = err_in;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (pop_s[1] && fq1.size() != 0) din1 = fq1.pop_front();
    else din1 = W'($urandom);
`ifdef FIFO_RD_STREAM_ERR_CHK_EN
    if (err_s) err_exp = 1'b1;
`endif
    refresh();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    check("rst_valid[0]", {31'd0, valid0}, 32'd0);
    check("rst_valid[1]", {31'd0, valid1}, 32'd0);
    check("rst_last[0]", {31'd0, last0}, 32'd0);
    check("rst_last[1]", {31'd0, last1}, 32'd0);
    check("rst_data[0]", {16'd0, dout0}, 32'd0);
    check("rst_data[1]", {16'd0, dout1}, 32'd0);
    check("rst_err[0]", {31'd0, err0}, 32'd0);
    check("rst_err[1]", {31'd0, err1}, 32'd0);
    fq0.delete(); fq1.delete(); exp_q0.delete(); exp_q1.delete();
    for (int i = 0; i < 2; i++) begin
      beat_m[i] = 0; stall_p[i] = 1'b0; pop_s[i] = 1'b0;
    end
    err_exp = 1'b0;
    refresh();
    rstn = 1'b1;
  endtask

  task automatic set_ready(input int mode, input int k);
    if (mode == 0) ready = 1'b1;
    else if (mode == 1) ready = (k % 2 == 0);
    else ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int mode, input int budget);
    int k;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < budget) begin
      set_ready(mode, k);
      step();
      k++;
    end
    check("drain_left", exp_q0.size() + exp_q1.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; ready = 1'b0; err_in = 1'b0; err_exp = 1'b0; din1 = '0;
    refresh();
    clear_stats();
    do_reset();

    // Streaming scenarios: {words, ready mode (0 always, 1 alternate, 2 random), beats, lasts}.
    vecs[0] = '{8, 0, 8, 2};
    vecs[1] = '{10, 1, 10, 2};
    vecs[2] = '{6, 2, 6, 1};
    vecs[3] = '{13, 2, 13, 3};
    vecs[4] = '{3, 0, 3, 0};
    for (int v = 0; v < 5; v++) begin
      do_reset();
      clear_stats();
      for (int k = 0; k < vecs[v].n_words; k++)
        push_word((v < 2) ? W'(k) : W'($urandom));
      drain(vecs[v].mode, 200);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("vec%0d_beats[%0d]", v, i), beats_n[i], vecs[v].exp_beats);
        check($sformatf("vec%0d_lasts[%0d]", v, i), lasts_n[i], vecs[v].exp_lasts);
        if (vecs[v].mode == 0)
          check($sformatf("vec%0d_back_to_back[%0d]", v, i), hs_last[i] - hs_first[i],
                vecs[v].n_words - 1);
      end
    end

    // Empty FIFO: no pops; one word gives one pop and valid RD_LATENCY+1 cycles later.
    do_reset();
    clear_stats();
    ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("empty_pops[0]", pops_n[0], 32'd0);
    check("empty_pops[1]", pops_n[1], 32'd0);
    clear_stats();
    push_word(16'hA5A5);
    for (int k = 0; k < 8; k++) step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("single_pops[%0d]", i), pops_n[i], 32'd1);
      check($sformatf("pop_to_valid[%0d]", i), valid_cyc[i] - pop_cyc[i], i + 1);
    end
    check("single_drained", exp_q0.size() + exp_q1.size(), 32'd0);

    // Backpressure: six words queued, consumer stalled for five cycles.
    do_reset();
    clear_stats();
    ready = 1'b0;
    for (int k = 0; k < 6; k++) push_word(W'(16'h0100 + k));
    for (int k = 0; k < 5; k++) step();
    check("bp_pops[0]", pops_n[0], 32'd2);
    check("bp_pops[1]", pops_n[1], 32'd2);
    check("bp_pop_req[0]", {31'd0, pop0}, 32'd0);
    check("bp_pop_req[1]", {31'd0, pop1}, 32'd0);
    check("bp_head[0]", {16'd0, dout0}, 32'h0100);
    check("bp_head[1]", {16'd0, dout1}, 32'h0100);
    drain(0, 100);
    check("bp_fifo_left", fq0.size() + fq1.size(), 32'd0);

    // Reset while streaming (a read in flight), then while saturated.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      clear_stats();
      for (int k = 0; k < 10; k++) push_word(W'(16'h0200 + k));
      ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      if (r == 1) begin
        ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
      end
      do_reset();
      clear_stats();
      ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      check($sformatf("no_capture_after_reset%0d[0]", r), {31'd0, valid_cyc[0] < 0}, 32'd1);
      check($sformatf("no_capture_after_reset%0d[1]", r), {31'd0, valid_cyc[1] < 0}, 32'd1);
      for (int k = 0; k < 5; k++) push_word(W'(16'h0300 + k));
      drain(0, 50);
      check($sformatf("post_reset_lasts%0d[1]", r), lasts_n[1], 32'd1);
    end

    // Error input pulsed for one cycle.
    do_reset();
    err_in = 1'b1;
    step();
    err_in = 1'b0;
    for (int k = 0; k < 4; k++) step();
`ifdef FIFO_RD_STREAM_ERR_CHK_EN
    check("err_sticky[0]", {31'd0, err0}, 32'd1);
    check("err_sticky[1]", {31'd0, err1}, 32'd1);
`else
    check("err_tied[0]", {31'd0, err0}, 32'd0);
    check("err_tied[1]", {31'd0, err1}, 32'd0);
`endif
    do_reset();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning word width of FIFO data and stream data.
REQ-002 SHALL have parameter RD_LATENCY, default 1, meaning cycles from pop_req to valid fifo_data_in; legal values 0 and 1.
REQ-003 SHALL have parameter PKT_LEN, default 4, meaning beats per packet for m_last_out; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1, the single clock; every flop SHALL be clocked on its rising edge.
REQ-005 SHALL have port rstn, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port fifo_empty_in, input, 1, upstream sync FIFO empty flag.
REQ-007 SHALL have port fifo_pop_req_out, output, 1, pop request to the upstream FIFO, active-high.
REQ-008 SHALL have port fifo_data_in, input, DATA_WIDTH, upstream FIFO read data.
REQ-009 SHALL have port fifo_error_in, input, 1, upstream FIFO error flag.
REQ-010 SHALL have port m_valid_out, output, 1, stream word valid.
REQ-011 SHALL have port m_ready_in, input, 1, stream consumer ready.
REQ-012 SHALL have port m_data_out, output, DATA_WIDTH, stream word.
REQ-013 SHALL have port m_last_out, output, 1, last beat of packet.
REQ-014 SHALL have port err_out, output, 1, sticky error.

Function
REQ-015 SHALL hold a 2-entry output buffer in FIFO order, with occupancy occ (0..2) and in-flight pop count infl (0..RD_LATENCY).
REQ-016 SHALL drive m_valid_out = (occ != 0), and m_data_out = the oldest buffer entry, both from registers.
REQ-017 SHALL define a handshake as m_valid_out && m_ready_in in the same cycle; on a handshake the head entry leaves at the clock edge.
REQ-018 SHALL drive fifo_pop_req_out = rstn && !fifo_empty_in && (occ + infl - handshake) < 2, combinationally.
REQ-019 SHALL capture fifo_data_in into the buffer in the pop cycle when RD_LATENCY=0, and in the cycle after the pop when RD_LATENCY=1.
REQ-020 SHALL give a latency from pop to m_valid_out high of RD_LATENCY+1 cycles into an empty buffer.
REQ-021 SHALL sustain one handshake per cycle, for either RD_LATENCY, while the FIFO is non-empty and m_ready_in is held high.
REQ-022 SHALL keep m_valid_out and m_data_out stable while m_valid_out && !m_ready_in.
REQ-023 SHALL support a simultaneous handshake and capture, with occ unchanged and order preserved.
REQ-024 SHALL hold beat counter beat_cnt of width clog2(PKT_LEN) (minimum 1), incremented on each handshake and wrapped from PKT_LEN-1 to 0.
REQ-025 SHALL drive m_last_out = m_valid_out && (beat_cnt == PKT_LEN-1); with PKT_LEN=1, m_last_out = m_valid_out.
REQ-026 SHALL issue no pop while fifo_empty_in is high, and SHALL never capture into a full buffer.

Reset
REQ-027 SHALL, on rstn low at a clock edge, clear occ, infl, beat_cnt and err to 0, giving m_valid_out=0, m_last_out=0, err_out=0 and m_data_out=0.
REQ-028 SHALL force fifo_pop_req_out=0 while rstn is low.
REQ-029 SHALL discard in-flight and buffered words when reset is asserted mid-operation, with no capture in the cycle following the reset edge.

Configuration
REQ-030 SHALL, with macro FIFO_RD_STREAM_ERR_CHK_EN defined, set err_out sticky-high on fifo_error_in=1 or on an internal buffer-overflow capture, cleared only by reset.
REQ-031 SHALL, without FIFO_RD_STREAM_ERR_CHK_EN, tie err_out to 0 and instantiate no error logic.

Verification
REQ-032 SHALL cover throughput: RD_LATENCY=1, 8 words 0..7 in FIFO, m_ready_in=1 -> m_valid_out high from pop+2, words 0..7 on 8 consecutive cycles, m_last_out on words 3 and 7.
REQ-033 SHALL cover backpressure: m_ready_in=0 for 5 cycles with 6 words queued -> occ saturates at 2, pops stop, m_data_out holds word 0; on release, words 0..5 appear in order with no loss.
REQ-034 SHALL cover empty: FIFO empty -> fifo_pop_req_out=0; one word pushed -> exactly one pop, and m_valid_out rises RD_LATENCY+1 cycles after the pop.
REQ-035 SHALL cover mid-operation reset: rstn=0 with occ=2 and infl=1 -> next cycle m_valid_out=0 and beat_cnt=0; the first post-reset word has m_last_out=0 (PKT_LEN=4).
REQ-036 SHALL cover error: macro defined, fifo_error_in pulsed for 1 cycle -> err_out=1 held until reset; macro undefined -> err_out=0 throughout.
REQ-037 SHALL cover RD_LATENCY=0 with alternating m_ready_in 1/0 over 10 words 0..9 -> output sequence 0..9, with m_last_out on beats 3 and 7.
